// File: rtl/bayer_demosaic.sv
// 2x2 bilinear Bayer demosaic: one line buffer plus a left-neighbour register pair.
// Each output pixel is built from the window ending at the current input sample (r,c).
module bayer_demosaic #(
  parameter int DATA_W   = 12,
  parameter int LINE_MAX = 2048,
  parameter int XY_W     = 16
) (
  input  logic              iCLK,
  input  logic              iRST,
  input  logic [DATA_W-1:0] iData,
  input  logic              iDval,
  input  logic              iSOF,
  input  logic [XY_W-1:0]   iLineLen,
  input  logic [1:0]        iPattern,
  output logic [DATA_W-1:0] oRed,
  output logic [DATA_W-1:0] oGreen,
  output logic [DATA_W-1:0] oBlue,
  output logic              oDval,
  output logic              oSOF,
  output logic [XY_W-1:0]   oX,
  output logic [XY_W-1:0]   oY,
  output logic              oErr
);

  localparam int AW = (LINE_MAX > 1) ? $clog2(LINE_MAX) : 1;
  localparam logic [XY_W:0] LEN_MAX = (XY_W+1)'(LINE_MAX);

  // frame state
  logic              r_started;
  logic              r_err;
  logic [XY_W-1:0]   r_len;
  logic [1:0]        r_pat;
  logic [XY_W-1:0]   r_col;
  logic [XY_W-1:0]   r_row;

  // window stage
  logic              r_s1_vld;
  logic [DATA_W-1:0] r_s1_cur;
  logic [XY_W-1:0]   r_s1_x;
  logic [XY_W-1:0]   r_s1_y;
  logic [1:0]        r_s1_pat;
  logic [DATA_W-1:0] r_lcur;
  logic [DATA_W-1:0] r_lup;
  logic [DATA_W-1:0] r_up;
  logic [DATA_W-1:0] r_mem [LINE_MAX];

  // output stage
  logic              r_dval;
  logic              r_sof;
  logic [DATA_W-1:0] r_red;
  logic [DATA_W-1:0] r_green;
  logic [DATA_W-1:0] r_blue;
  logic [XY_W-1:0]   r_x;
  logic [XY_W-1:0]   r_y;

  logic              w_sof;
  logic              w_len_ok;
  logic              w_run;
  logic              w_wr;
  logic [XY_W-1:0]   w_len;
  logic [XY_W-1:0]   w_c;
  logic [XY_W-1:0]   w_r;
  logic [1:0]        w_pat;
  logic [AW-1:0]     w_addr;
  logic              w_last;

  // A qualified SOF takes effect on its own pixel, so frame fields are muxed in here.
  assign w_sof    = iDval & iSOF;
  assign w_len_ok = ({1'b0, iLineLen} >= (XY_W+1)'(2)) && ({1'b0, iLineLen} <= LEN_MAX);
  assign w_len    = w_sof ? iLineLen : r_len;
  assign w_pat    = w_sof ? iPattern : r_pat;
  assign w_c      = w_sof ? '0 : r_col;
  assign w_r      = w_sof ? '0 : r_row;
  assign w_run    = w_sof ? w_len_ok : (r_started & ~r_err);
  assign w_wr     = iDval & w_run;
  assign w_addr   = w_c[AW-1:0];
  assign w_last   = (w_c == w_len - XY_W'(1));

  always_ff @(posedge iCLK) begin
    if (w_wr) begin
      r_mem[w_addr] <= iData;
    end
    r_up <= r_mem[w_addr];
  end

  logic [1:0]        w_ph;
  logic [DATA_W-1:0] w_red;
  logic [DATA_W-1:0] w_blue;
  logic [DATA_W-1:0] w_ga;
  logic [DATA_W-1:0] w_gb;
  logic [DATA_W:0]   w_gsum;
  logic [DATA_W-1:0] w_ghalf;
  logic              w_emit;

  // Phase of the current sample relative to the R site: 00 = on R, 11 = on B.
  assign w_ph = {r_s1_y[0] ^ r_s1_pat[1], r_s1_x[0] ^ r_s1_pat[0]};

  always_comb begin
    w_red  = r_s1_cur;
    w_blue = r_lup;
    w_ga   = r_up;
    w_gb   = r_lcur;
    case (w_ph)
      2'b00: begin w_red = r_s1_cur; w_blue = r_lup;    w_ga = r_up;     w_gb = r_lcur; end
      2'b11: begin w_red = r_lup;    w_blue = r_s1_cur; w_ga = r_up;     w_gb = r_lcur; end
      2'b01: begin w_red = r_lcur;   w_blue = r_up;     w_ga = r_s1_cur; w_gb = r_lup;  end
      default: begin w_red = r_up;   w_blue = r_lcur;   w_ga = r_s1_cur; w_gb = r_lup;  end
    endcase
  end

  assign w_gsum  = {1'b0, w_ga} + {1'b0, w_gb};
  assign w_ghalf = DATA_W'(w_gsum >> 1);
  assign w_emit  = r_s1_vld && (r_s1_x != '0) && (r_s1_y != '0);

  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      r_started <= 1'b0;
      r_err     <= 1'b0;
      r_len     <= '0;
      r_pat     <= '0;
      r_col     <= '0;
      r_row     <= '0;
      r_s1_vld  <= 1'b0;
      r_s1_cur  <= '0;
      r_s1_x    <= '0;
      r_s1_y    <= '0;
      r_s1_pat  <= '0;
      r_lcur    <= '0;
      r_lup     <= '0;
      r_dval    <= 1'b0;
      r_sof     <= 1'b0;
      r_red     <= '0;
      r_green   <= '0;
      r_blue    <= '0;
      r_x       <= '0;
      r_y       <= '0;
    end else begin
      if (w_sof) begin
        r_started <= 1'b1;
        r_err     <= ~w_len_ok;
        r_len     <= iLineLen;
        r_pat     <= iPattern;
      end
      if (w_wr) begin
        r_col    <= w_last ? '0 : w_c + XY_W'(1);
        r_row    <= w_last ? w_r + XY_W'(1) : w_r;
        r_s1_cur <= iData;
        r_s1_x   <= w_c;
        r_s1_y   <= w_r;
        r_s1_pat <= w_pat;
      end
      r_s1_vld <= w_wr;
      // The previous accepted sample is always the left neighbour of the next one.
      if (r_s1_vld) begin
        r_lcur <= r_s1_cur;
        r_lup  <= r_up;
      end
      r_dval <= w_emit;
      r_sof  <= w_emit && (r_s1_x == XY_W'(1)) && (r_s1_y == XY_W'(1));
      if (w_emit) begin
        r_red   <= w_red;
        r_green <= w_ghalf;
        r_blue  <= w_blue;
        r_x     <= r_s1_x;
        r_y     <= r_s1_y;
      end
    end
  end

  assign oRed   = r_red;
  assign oGreen = r_green;
  assign oBlue  = r_blue;
  assign oDval  = r_dval;
  assign oSOF   = r_sof;
  assign oX     = r_x;
  assign oY     = r_y;
  assign oErr   = r_err;

endmodule

// File: tb/tb_bayer_demosaic.sv
// Randomised frame bench for bayer_demosaic against a per-window colour-classification model.
module tb_bayer_demosaic;
  localparam int DW = 12;
  localparam int LM = 64;
  localparam int XW = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic [DW-1:0] iData;
  logic          iDval, iSOF;
  logic [XW-1:0] iLineLen;
  logic [1:0]    iPattern;
  logic [DW-1:0] oRed, oGreen, oBlue;
  logic          oDval, oSOF, oErr;
  logic [XW-1:0] oX, oY;

  bayer_demosaic #(.DATA_W(DW), .LINE_MAX(LM), .XY_W(XW)) dut (
    .iCLK(clk), .iRST(rst), .iData(iData), .iDval(iDval), .iSOF(iSOF),
    .iLineLen(iLineLen), .iPattern(iPattern), .oRed(oRed), .oGreen(oGreen),
    .oBlue(oBlue), .oDval(oDval), .oSOF(oSOF), .oX(oX), .oY(oY), .oErr(oErr)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct packed {
    logic [31:0] r, g, b, x, y, sof, cyc;
  } pix_t;

  pix_t obs_q[$];
  pix_t exp_q[$];
  int   img[0:7][0:79];
  int   drv[0:7][0:79];
  int   errors = 0;
  int   checks = 0;

  always @(negedge clk) begin
    if (oDval === 1'b1) begin
      pix_t p;
      p.r = 32'(oRed);  p.g = 32'(oGreen); p.b = 32'(oBlue);
      p.x = 32'(oX);    p.y = 32'(oY);     p.sof = {31'd0, oSOF};
      p.cyc = cyc;
      obs_q.push_back(p);
    end
  end

  // 0 = R, 1 = G, 2 = B at absolute site (y,x); pattern gives the R site in the 2x2 tile.
  function automatic int colour(int y, int x, int pat);
    int rr = (pat >> 1) & 1;
    int rc = pat & 1;
    if ((y % 2) == rr && (x % 2) == rc) return 0;
    if ((y % 2) != rr && (x % 2) != rc) return 2;
    return 1;
  endfunction

  task automatic build_exp(input int h, input int len, input int pat);
    exp_q.delete();
    for (int r = 1; r < h; r++) begin
      for (int c = 1; c < len; c++) begin
        pix_t e;
        int gs = 0;
        e = '0;
        for (int dy = 0; dy < 2; dy++) begin
          for (int dx = 0; dx < 2; dx++) begin
            int v = img[r-1+dy][c-1+dx];
            case (colour(r-1+dy, c-1+dx, pat))
              0: e.r = v;
              2: e.b = v;
              default: gs += v;
            endcase
          end
        end
        e.g = gs / 2;
        e.x = c; e.y = r;
        e.sof = (r == 1 && c == 1) ? 1 : 0;
        e.cyc = drv[r][c] + 2;
        exp_q.push_back(e);
      end
    end
  endtask

  task automatic fill(input int h, input int len);
    for (int r = 0; r < h; r++)
      for (int c = 0; c < len; c++)
        img[r][c] = $urandom_range(0, 4095);
  endtask

  // gap: 0 none, 1 one idle cycle between pixels, 2 random 0..2 idle cycles
  task automatic drive(input int h, input int len, input int pat, input int gap, input int limit);
    int n = 0;
    for (int r = 0; r < h; r++) begin
      for (int c = 0; c < len; c++) begin
        int ng;
        if (n == limit) return;
        ng = (gap == 1) ? ((n > 0) ? 1 : 0) : (gap == 2) ? $urandom_range(0, 2) : 0;
        repeat (ng) begin
          @(posedge clk); #1;
          iDval = 1'b0; iData = DW'($urandom); iSOF = 1'($urandom);
          iLineLen = XW'($urandom_range(0, 100)); iPattern = 2'($urandom);
        end
        @(posedge clk); #1;
        iDval = 1'b1;
        iData = DW'(img[r][c]);
        iSOF  = (r == 0 && c == 0);
        iLineLen = iSOF ? XW'(len) : XW'($urandom_range(1, 100));
        iPattern = iSOF ? 2'(pat) : 2'($urandom);
        drv[r][c] = cyc;
        n++;
      end
    end
    @(posedge clk); #1;
    iDval = 1'b0; iSOF = 1'b0;
  endtask

  task automatic settle();
    repeat (6) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    #2;
    checks++;
    if (oDval !== 1'b0 || oSOF !== 1'b0 || oErr !== 1'b0) begin
      errors++; $display("FAIL reset_flags: got dval=%b sof=%b err=%b expected 0 0 0", oDval, oSOF, oErr);
    end
    checks++;
    if (oRed !== 0 || oGreen !== 0 || oBlue !== 0 || oX !== 0 || oY !== 0) begin
      errors++; $display("FAIL reset_data: got r=%0d g=%0d b=%0d x=%0d y=%0d expected all 0", oRed, oGreen, oBlue, oX, oY);
    end
    @(posedge clk); #1 rst = 1'b0;
    obs_q.delete();
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1;
      iDval = 1'b1; iSOF = 1'b0; iData = DW'($urandom); iLineLen = 4;
    end
    @(posedge clk); #1 iDval = 1'b0;
    settle();
    checks++;
    if (obs_q.size() !== 0) begin
      errors++; $display("FAIL pre_sof: got %0d outputs expected 0", obs_q.size());
    end
    $display("test_reset done");
  endtask

  task automatic test_directed();
    int want_r, want_b;
    for (int pat = 0; pat < 4; pat += 3) begin
      for (int c = 0; c < 4; c++) begin
        img[0][c] = (c % 2 == 0) ? 100 : 200;
        img[1][c] = (c % 2 == 0) ? 300 : 400;
      end
      obs_q.delete();
      drive(2, 4, pat, 0, -1);
      settle();
      want_r = (pat == 0) ? 100 : 400;
      want_b = (pat == 0) ? 400 : 100;
      checks++;
      if (obs_q.size() !== 3) begin
        errors++; $display("FAIL dir_count pat=%0d: got %0d expected 3", pat, obs_q.size());
      end
      for (int i = 0; i < obs_q.size() && i < 3; i++) begin
        checks++;
        if (obs_q[i].r !== want_r || obs_q[i].g !== 250 || obs_q[i].b !== want_b ||
            obs_q[i].x !== i + 1 || obs_q[i].y !== 1 || obs_q[i].sof !== (i == 0 ? 1 : 0) ||
            obs_q[i].cyc !== drv[1][i+1] + 2) begin
          errors++;
          $display("FAIL dir_pix pat=%0d i=%0d: got r=%0d g=%0d b=%0d x=%0d y=%0d sof=%0d cyc=%0d expected r=%0d g=250 b=%0d x=%0d y=1 sof=%0d cyc=%0d",
                   pat, i, obs_q[i].r, obs_q[i].g, obs_q[i].b, obs_q[i].x, obs_q[i].y, obs_q[i].sof,
                   obs_q[i].cyc, want_r, want_b, i + 1, (i == 0), drv[1][i+1] + 2);
        end
      end
      $display("test_directed pattern=%0d outputs=%0d", pat, obs_q.size());
    end
  endtask

  task automatic test_green_max();
    img[0][0] = 17; img[0][1] = 4095; img[1][0] = 4094; img[1][1] = 4000;
    obs_q.delete();
    drive(2, 2, 0, 0, -1);
    settle();
    checks++;
    if (obs_q.size() !== 1 || obs_q[0].g !== 4094 || obs_q[0].r !== 17 || obs_q[0].b !== 4000) begin
      errors++;
      $display("FAIL green_max: got n=%0d g=%0d r=%0d b=%0d expected n=1 g=4094 r=17 b=4000",
               obs_q.size(), (obs_q.size() > 0) ? obs_q[0].g : 0,
               (obs_q.size() > 0) ? obs_q[0].r : 0, (obs_q.size() > 0) ? obs_q[0].b : 0);
    end
    $display("test_green_max outputs=%0d", obs_q.size());
  endtask

  task automatic test_random();
    for (int f = 0; f < 5; f++) begin
      int h   = $urandom_range(2, 8);
      int len = (f == 4) ? LM : $urandom_range(2, 20);
      int pat = $urandom_range(0, 3);
      fill(h, len);
      obs_q.delete();
      drive(h, len, pat, 2, -1);
      settle();
      build_exp(h, len, pat);
      checks++;
      if (obs_q.size() !== exp_q.size()) begin
        errors++; $display("FAIL rand_count f=%0d: got %0d expected %0d", f, obs_q.size(), exp_q.size());
      end
      for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
        checks++;
        if (obs_q[i] !== exp_q[i]) begin
          errors++;
          $display("FAIL rand_pix f=%0d i=%0d: got %0d/%0d/%0d @(%0d,%0d) sof=%0d cyc=%0d expected %0d/%0d/%0d @(%0d,%0d) sof=%0d cyc=%0d",
                   f, i, obs_q[i].r, obs_q[i].g, obs_q[i].b, obs_q[i].x, obs_q[i].y, obs_q[i].sof, obs_q[i].cyc,
                   exp_q[i].r, exp_q[i].g, exp_q[i].b, exp_q[i].x, exp_q[i].y, exp_q[i].sof, exp_q[i].cyc);
        end
      end
      $display("test_random frame=%0d h=%0d len=%0d pat=%0d outputs=%0d", f, h, len, pat, obs_q.size());
    end
  endtask

  task automatic test_back_to_back();
    pix_t first_q[$];
    fill(6, 8);
    for (int run = 0; run < 2; run++) begin
      obs_q.delete();
      drive(6, 8, 1, run, -1);
      settle();
      build_exp(6, 8, 1);
      checks++;
      if (obs_q.size() !== 35) begin
        errors++; $display("FAIL gap_count run=%0d: got %0d expected 35", run, obs_q.size());
      end
      for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
        checks++;
        if (obs_q[i] !== exp_q[i] || (run == 1 && obs_q[i][223:32] !== first_q[i][223:32])) begin
          errors++;
          $display("FAIL gap_pix run=%0d i=%0d: got %0d/%0d/%0d @(%0d,%0d) cyc=%0d expected %0d/%0d/%0d @(%0d,%0d) cyc=%0d",
                   run, i, obs_q[i].r, obs_q[i].g, obs_q[i].b, obs_q[i].x, obs_q[i].y, obs_q[i].cyc,
                   exp_q[i].r, exp_q[i].g, exp_q[i].b, exp_q[i].x, exp_q[i].y, exp_q[i].cyc);
        end
      end
      if (run == 0) first_q = obs_q;
      $display("test_back_to_back gapmode=%0d outputs=%0d", run, obs_q.size());
    end
  endtask

  task automatic test_err();
    int lens[2] = '{1, LM + 1};
    for (int k = 0; k < 2; k++) begin
      fill(3, lens[k]);
      obs_q.delete();
      drive(3, lens[k], 0, 0, -1);
      settle();
      checks++;
      if (oErr !== 1'b1 || obs_q.size() !== 0) begin
        errors++; $display("FAIL err_len%0d: got err=%b outputs=%0d expected err=1 outputs=0", lens[k], oErr, obs_q.size());
      end
      $display("test_err len=%0d err=%b", lens[k], oErr);
    end
    fill(4, 8);
    obs_q.delete();
    drive(4, 8, 2, 0, -1);
    settle();
    build_exp(4, 8, 2);
    checks++;
    if (oErr !== 1'b0 || obs_q.size() !== exp_q.size()) begin
      errors++; $display("FAIL err_recover: got err=%b outputs=%0d expected err=0 outputs=%0d", oErr, obs_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      checks++;
      if (obs_q[i] !== exp_q[i]) begin
        errors++; $display("FAIL err_pix i=%0d: got %0d/%0d/%0d expected %0d/%0d/%0d",
                           i, obs_q[i].r, obs_q[i].g, obs_q[i].b, exp_q[i].r, exp_q[i].g, exp_q[i].b);
      end
    end
    $display("test_err recovery outputs=%0d", obs_q.size());
  endtask

  task automatic test_reset_mid();
    logic pre_dval;
    fill(6, 10);
    drive(6, 10, 3, 0, 34);
    #1 pre_dval = oDval;
    #1 rst = 1'b1;
    #1;
    checks++;
    if (pre_dval !== 1'b1 || oDval !== 1'b0 || oSOF !== 1'b0 || oRed !== 0 || oGreen !== 0 ||
        oBlue !== 0 || oX !== 0 || oY !== 0) begin
      errors++;
      $display("FAIL rst_mid: got pre_dval=%b dval=%b sof=%b r=%0d g=%0d b=%0d x=%0d y=%0d expected 1 then all 0",
               pre_dval, oDval, oSOF, oRed, oGreen, oBlue, oX, oY);
    end
    iDval = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    obs_q.delete();
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      iDval = 1'b1; iSOF = 1'b0; iData = DW'($urandom);
    end
    @(posedge clk); #1 iDval = 1'b0;
    settle();
    checks++;
    if (obs_q.size() !== 0) begin
      errors++; $display("FAIL rst_wait: got %0d outputs expected 0", obs_q.size());
    end
    fill(5, 9);
    obs_q.delete();
    drive(5, 9, 1, 2, -1);
    settle();
    build_exp(5, 9, 1);
    checks++;
    if (obs_q.size() !== exp_q.size()) begin
      errors++; $display("FAIL rst_count: got %0d expected %0d", obs_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      checks++;
      if (obs_q[i] !== exp_q[i]) begin
        errors++; $display("FAIL rst_pix i=%0d: got %0d/%0d/%0d cyc=%0d expected %0d/%0d/%0d cyc=%0d",
                           i, obs_q[i].r, obs_q[i].g, obs_q[i].b, obs_q[i].cyc,
                           exp_q[i].r, exp_q[i].g, exp_q[i].b, exp_q[i].cyc);
      end
    end
    $display("test_reset_mid outputs=%0d", obs_q.size());
  endtask

  initial begin
    rst = 1'b1; iData = '0; iDval = 1'b0; iSOF = 1'b0; iLineLen = '0; iPattern = '0;
    test_reset();
    test_directed();
    test_green_max();
    test_random();
    test_back_to_back();
    test_err();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
